// File: rtl/fft32_sequencer_if.sv
// rtl/fft32_sequencer_if.sv - stream handshakes and butterfly address bus of the FFT sequencer
interface fft32_sequencer_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic       bf_issue;
    logic [4:0] addr_a;
    logic [4:0] addr_b;
    logic [3:0] tw_idx;
    logic [2:0] stage;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] rd_addr;
    logic       busy;
    logic       done;

    // Controller side: stimulus into the sequencer, addresses and strobes back.
    modport master (
        output start, in_valid, out_ready,
        input  in_ready, wr_en, wr_addr, bf_issue, addr_a, addr_b, tw_idx,
               stage, out_valid, rd_addr, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, wr_en, wr_addr, bf_issue, addr_a, addr_b, tw_idx,
               stage, out_valid, rd_addr, busy, done
    );
endinterface

// File: rtl/fft32_sequencer.sv
// rtl/fft32_sequencer.sv - load/compute/drain/unload sequencer for the 32-point radix-2 DIT FFT
module fft32_sequencer #(
    parameter int unsigned BF_LAT = 3
) (
    input  logic             clk,
    input  logic             clr,
    fft32_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_WAIT,
        S_UNLOAD,
        S_DONE
    } state_t;

    // Terminal value of the drain counter; unused when there is no drain.
    localparam logic [2:0] LAT_LAST = 3'((BF_LAT == 0) ? 0 : (BF_LAT - 1));

    state_t     state_q, state_d;
    logic [4:0] n_q, n_d;
    logic [3:0] j_q, j_d;
    logic [2:0] s_q, s_d;
    logic [2:0] w_q, w_d;
    logic [4:0] m_q, m_d;
    logic       stage_end;

    // Butterfly geometry for the current (s, j).
    logic [4:0] span;
    logic [3:0] pos;
    logic [3:0] grp;
    logic [4:0] base_a;

    // Next-state and counter update; a stage ends after the drain, or at j=15 with no drain.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        j_d       = j_q;
        s_d       = s_q;
        w_d       = w_q;
        m_d       = m_q;
        stage_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    n_d     = 5'd0;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (n_q == 5'd31) begin
                        state_d = S_COMPUTE;
                        n_d     = 5'd0;
                        j_d     = 4'd0;
                        s_d     = 3'd0;
                    end else begin
                        n_d = n_q + 5'd1;
                    end
                end
            end
            S_COMPUTE: begin
                if (j_q == 4'd15) begin
                    j_d = 4'd0;
                    if (BF_LAT == 0) begin
                        stage_end = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        w_d     = 3'd0;
                    end
                end else begin
                    j_d = j_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (w_q == LAT_LAST) begin
                    stage_end = 1'b1;
                    w_d       = 3'd0;
                end else begin
                    w_d = w_q + 3'd1;
                end
            end
            S_UNLOAD: begin
                if (bus.out_ready) begin
                    if (m_q == 5'd31) begin
                        state_d = S_DONE;
                        m_d     = 5'd0;
                    end else begin
                        m_d = m_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stage_end) begin
            j_d = 4'd0;
            if (s_q == 3'd4) begin
                state_d = S_UNLOAD;
                s_d     = 3'd0;
                m_d     = 5'd0;
            end else begin
                state_d = S_COMPUTE;
                s_d     = s_q + 3'd1;
            end
        end
    end

    // State and counter registers; clr aborts any transform back to IDLE.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            n_q     <= 5'd0;
            j_q     <= 4'd0;
            s_q     <= 3'd0;
            w_q     <= 3'd0;
            m_q     <= 5'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            j_q     <= j_d;
            s_q     <= s_d;
            w_q     <= w_d;
            m_q     <= m_d;
        end
    end

    // Operand geometry: span = 2^s, group and position of butterfly j inside its group.
    // span[3:0]-1 wraps to 4'hF at s=4, which is exactly the mask needed there.
    always_comb begin
        span   = 5'd1 << s_q;
        pos    = j_q & (span[3:0] - 4'd1);
        grp    = j_q >> s_q;
        base_a = ({1'b0, grp} << (s_q + 3'd1)) | {1'b0, pos};
    end

    // Output decode: every address is forced to 0 outside the phase that owns it.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 5'd0;
        bus.bf_issue  = 1'b0;
        bus.addr_a    = 5'd0;
        bus.addr_b    = 5'd0;
        bus.tw_idx    = 4'd0;
        bus.stage     = 3'd0;
        bus.out_valid = 1'b0;
        bus.rd_addr   = 5'd0;
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        case (state_q)
            S_LOAD: begin
                bus.in_ready = 1'b1;
                bus.wr_en    = bus.in_valid;
                if (bus.in_valid) begin
                    bus.wr_addr = {n_q[0], n_q[1], n_q[2], n_q[3], n_q[4]};
                end
            end
            S_COMPUTE: begin
                bus.bf_issue = 1'b1;
                bus.addr_a   = base_a;
                bus.addr_b   = base_a + span;
                bus.tw_idx   = pos << (3'd4 - s_q);
                bus.stage    = s_q;
            end
            S_WAIT: begin
                bus.stage = s_q;
            end
            S_UNLOAD: begin
                bus.out_valid = 1'b1;
                bus.rd_addr   = m_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/fft32_sequencer.md
# fft32_sequencer

Control sequencer for the 32-point radix-2 DIT FFT core. It drives the shared 5-bit sample/butterfly counters through four phases: load (bit-reversed write), compute (5 stages × 16 butterflies), drain, and unload (natural-order read). It generates the sample-memory addresses, twiddle index and butterfly-issue strobes consumed by the butterfly datapath, and handshakes with the input and output streams.

## Interface

**Parameters**
- `BF_LAT`, default 3: cycles from `bf_issue` to butterfly write-back complete. Legal range 0..7.

**Ports**
- `clk` in 1: single clock; all state changes on the rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `start` in 1: begin a transform. Sampled only in IDLE.
- `in_valid` in 1: input sample present.
- `in_ready` out 1: sequencer accepts an input sample.
- `wr_en` out 1: write the input sample this cycle (`in_valid & in_ready`).
- `wr_addr` out 5: bit-reversed write address for the input sample.
- `bf_issue` out 1: butterfly issued this cycle.
- `addr_a` out 5: upper butterfly operand address.
- `addr_b` out 5: lower butterfly operand address.
- `tw_idx` out 4: twiddle index k for W32^k.
- `stage` out 3: current stage, 0..4.
- `out_valid` out 1: output sample available at `rd_addr`.
- `out_ready` in 1: consumer accepts the output sample.
- `rd_addr` out 5: natural-order read address.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at transform completion.

## Operation

**States:** IDLE, LOAD, COMPUTE, WAIT, UNLOAD, DONE.

**Internal counters** (each with enable and synchronous clear):
- `n`: 5-bit, load index.
- `j`: 4-bit, butterfly index.
- `s`: 3-bit, stage.
- `w`: 3-bit, wait count.
- `m`: 5-bit, unload index.

**Transitions**
- IDLE → LOAD when `start`=1. `start` is ignored in all other states.
- LOAD:
  - `in_ready`=1.
  - On `in_valid`: `wr_en`=1, `wr_addr`=rev5(n), and n increments.
  - Accepting the sample at n=31 → COMPUTE, with j=0 and s=0.
- COMPUTE: `bf_issue`=1 every cycle, with no stall.
  - Let span = 1<<s, group = j>>s, pos = j & (span−1).
  - `addr_a` = (group<<(s+1)) | pos.
  - `addr_b` = `addr_a` + span.
  - `tw_idx` = pos<<(4−s).
  - At j=15: if `BF_LAT`>0 → WAIT, otherwise advance the stage directly.
- WAIT:
  - `bf_issue`=0; hold for `BF_LAT` cycles.
  - Then, if s<4 → COMPUTE with s+1 and j=0.
  - If s=4 → UNLOAD with m=0.
  - With `BF_LAT`=0 the same decision is taken at j=15.
- UNLOAD:
  - `out_valid`=1 and `rd_addr`=m.
  - On `out_ready`, m increments.
  - The transfer at m=31 → DONE.
- DONE: `done`=1 for one cycle, then IDLE.

**Output rules**
- Address and strobe outputs are combinational from the state and counters, valid in the same cycle as their strobe.
- Outside its active state, each output is 0: `wr_addr`, `addr_a`, `addr_b`, `tw_idx`, `rd_addr`.
- `stage` holds s during COMPUTE and WAIT and is 0 elsewhere.

**Reset:** `clr`=1 in any state, including mid-LOAD, COMPUTE or UNLOAD, aborts the transform. On the next edge the state is IDLE and all counters are 0. The reset value of every output is 0.

**Width rules**
- All address arithmetic is 5-bit, with no overflow by construction.
- n and m wrap 31→0 only on exit from their phase.

## Timing

- `start` in IDLE → LOAD, with `in_ready`=1, on the next cycle.
- LOAD takes at least 32 cycles. Gaps in `in_valid` stretch it, with no lost or duplicated addresses.
- COMPUTE plus WAIT is exactly 5×(16+`BF_LAT`) cycles.
- The first `out_valid` comes 5×(16+`BF_LAT`) cycles after the first `bf_issue`.
- UNLOAD takes at least 32 cycles. When `out_ready`=0, `rd_addr` and `out_valid` hold.
- `done` rises the cycle after the last output transfer. `busy` falls the cycle after `done`.
- Minimum total from `start` to `done` at `BF_LAT`=3: 1 + 32 + 95 + 32 = 160 cycles.

## Test plan

1. **Reset:** assert `clr` for 2 cycles → all outputs 0, `busy`=0. Pulse `start` while `clr`=1 → remains IDLE.
2. **Load ordering:** `start`, then continuous `in_valid` → `wr_addr` sequence 0, 16, 8, 24, 4, …, 31. Insert 3-cycle `in_valid` gaps → same sequence, `wr_en` low during the gaps.
3. **Butterfly addressing:**
   - s=0, j=15 → a=30, b=31, tw=0.
   - s=2, j=5 → a=9, b=13, tw=4.
   - s=4, j=15 → a=15, b=31, tw=15.
   - Each stage covers all 32 addresses exactly once.
4. **Stage pacing:** `BF_LAT`=3 → `bf_issue` pattern of 16 high, 3 low, repeated 5 times, then `out_valid`=1. `BF_LAT`=0 → 80 consecutive `bf_issue` cycles.
5. **Unload backpressure:** toggle `out_ready` randomly → `rd_addr` 0..31 in order, each transferred once, then `done` pulses once and `busy`=0.
6. **Abort:** `clr` at s=2, j=7 → IDLE next cycle, `bf_issue`=0. A following `start` runs a full transform with `wr_addr` starting at 0.
